// File: rtl/mfp_ahb_master_arbiter.sv
// rtl/mfp_ahb_master_arbiter.sv - two-master AHB-Lite arbiter (CPU m0, S-record loader m1) with cut-off transfer replay
//
// Ports:
//   HCLK, HRESET            clock, synchronous active-high reset
//   m0_* / m1_*             master request in (HADDR..HWRITE), response out (HRDATA, HREADY, HRESP)
//   m1_busreq               loader wants the bus
//   s_*                     address/control/write data to the slave fabric, response back
//   addr_owner              0 = CPU, 1 = loader owns the address phase
//   buf_valid               bit n = master n has a captured address phase awaiting replay
module mfp_ahb_master_arbiter #(
    parameter int ADDR_W     = 32,
    parameter bit HONOR_LOCK = 1'b1
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic [ADDR_W-1:0] m0_HADDR,
    input  logic [2:0]        m0_HBURST,
    input  logic              m0_HMASTLOCK,
    input  logic [3:0]        m0_HPROT,
    input  logic [2:0]        m0_HSIZE,
    input  logic [1:0]        m0_HTRANS,
    input  logic [ADDR_W-1:0] m0_HWDATA,
    input  logic              m0_HWRITE,
    output logic [ADDR_W-1:0] m0_HRDATA,
    output logic              m0_HREADY,
    output logic              m0_HRESP,
    input  logic [ADDR_W-1:0] m1_HADDR,
    input  logic [2:0]        m1_HBURST,
    input  logic              m1_HMASTLOCK,
    input  logic [3:0]        m1_HPROT,
    input  logic [2:0]        m1_HSIZE,
    input  logic [1:0]        m1_HTRANS,
    input  logic [ADDR_W-1:0] m1_HWDATA,
    input  logic              m1_HWRITE,
    output logic [ADDR_W-1:0] m1_HRDATA,
    output logic              m1_HREADY,
    output logic              m1_HRESP,
    input  logic              m1_busreq,
    output logic [ADDR_W-1:0] s_HADDR,
    output logic [2:0]        s_HBURST,
    output logic              s_HMASTLOCK,
    output logic [3:0]        s_HPROT,
    output logic [2:0]        s_HSIZE,
    output logic [1:0]        s_HTRANS,
    output logic [ADDR_W-1:0] s_HWDATA,
    output logic              s_HWRITE,
    input  logic [ADDR_W-1:0] s_HRDATA,
    input  logic              s_HREADY,
    input  logic              s_HRESP,
    output logic              addr_owner,
    output logic [1:0]        buf_valid
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    logic data_owner;
    logic data_valid;

    logic [ADDR_W-1:0] buf_haddr  [2];
    logic [2:0]        buf_hburst [2];
    logic              buf_hlock  [2];
    logic [3:0]        buf_hprot  [2];
    logic [2:0]        buf_hsize  [2];
    logic [1:0]        buf_htrans [2];
    logic              buf_hwrite [2];

    logic [ADDR_W-1:0] live_haddr;
    logic [2:0]        live_hburst;
    logic              live_hlock;
    logic [3:0]        live_hprot;
    logic [2:0]        live_hsize;
    logic [1:0]        live_htrans;
    logic              live_hwrite;
    logic              at_boundary;
    logic              ho_req;

    // Live request of whichever master owns the address phase.
    always_comb begin
        live_haddr  = m0_HADDR;
        live_hburst = m0_HBURST;
        live_hlock  = m0_HMASTLOCK;
        live_hprot  = m0_HPROT;
        live_hsize  = m0_HSIZE;
        live_htrans = m0_HTRANS;
        live_hwrite = m0_HWRITE;
        if (addr_owner) begin
            live_haddr  = m1_HADDR;
            live_hburst = m1_HBURST;
            live_hlock  = m1_HMASTLOCK;
            live_hprot  = m1_HPROT;
            live_hsize  = m1_HSIZE;
            live_htrans = m1_HTRANS;
            live_hwrite = m1_HWRITE;
        end
    end

    // A pending replay must be issued before the bus may change hands again,
    // and burst continuations (SEQ/BUSY) and locked sequences keep the bus.
    // ho_req is deliberately independent of s_HREADY so s_HTRANS has no
    // combinational path from the slave's ready.
    always_comb begin
        at_boundary = ((live_htrans == HTRANS_IDLE) || (live_htrans == HTRANS_NONSEQ))
                      && !(HONOR_LOCK && live_hlock)
                      && !buf_valid[addr_owner];
        ho_req      = at_boundary && (m1_busreq != addr_owner);
    end

    // While a handover is pending the owner's address phase is hidden from
    // the slave (forced IDLE); if it was NONSEQ it is captured and replayed.
    always_comb begin
        s_HADDR     = live_haddr;
        s_HBURST    = live_hburst;
        s_HMASTLOCK = live_hlock;
        s_HPROT     = live_hprot;
        s_HSIZE     = live_hsize;
        s_HTRANS    = live_htrans;
        s_HWRITE    = live_hwrite;
        if (buf_valid[addr_owner]) begin
            s_HADDR     = buf_haddr[addr_owner];
            s_HBURST    = buf_hburst[addr_owner];
            s_HMASTLOCK = buf_hlock[addr_owner];
            s_HPROT     = buf_hprot[addr_owner];
            s_HSIZE     = buf_hsize[addr_owner];
            s_HTRANS    = buf_htrans[addr_owner];
            s_HWRITE    = buf_hwrite[addr_owner];
        end else if (ho_req) begin
            s_HTRANS = HTRANS_IDLE;
        end
    end

    assign s_HWDATA = data_owner ? m1_HWDATA : m0_HWDATA;

    // A master with a captured transfer is stalled; it next sees HREADY=1 on
    // the edge that completes the replayed transfer's data phase. The data
    // owner only counts while a real transfer is in its data phase, so an
    // outgoing master that went idle cannot mistake a later edge for acceptance.
    assign m0_HREADY = s_HREADY && !buf_valid[0]
                       && (!addr_owner || (!data_owner && data_valid));
    assign m1_HREADY = s_HREADY && !buf_valid[1]
                       && (addr_owner || (data_owner && data_valid));

    assign m0_HRDATA = s_HRDATA;
    assign m1_HRDATA = s_HRDATA;
    assign m0_HRESP  = s_HRESP;
    assign m1_HRESP  = s_HRESP;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            addr_owner <= 1'b0;
            data_owner <= 1'b0;
            data_valid <= 1'b0;
            buf_valid  <= 2'b00;
        end else if (s_HREADY) begin
            data_owner <= addr_owner;
            data_valid <= s_HTRANS[1];
            if (buf_valid[addr_owner]) begin
                buf_valid[addr_owner] <= 1'b0;
            end else if (ho_req) begin
                addr_owner <= ~addr_owner;
                if (live_htrans == HTRANS_NONSEQ) begin
                    buf_valid[addr_owner]  <= 1'b1;
                    buf_haddr[addr_owner]  <= live_haddr;
                    buf_hburst[addr_owner] <= live_hburst;
                    buf_hlock[addr_owner]  <= live_hlock;
                    buf_hprot[addr_owner]  <= live_hprot;
                    buf_hsize[addr_owner]  <= live_hsize;
                    buf_htrans[addr_owner] <= live_htrans;
                    buf_hwrite[addr_owner] <= live_hwrite;
                end
            end
        end
    end

endmodule

// File: tb/tb_mfp_ahb_master_arbiter.sv
// tb/tb_mfp_ahb_master_arbiter.sv - directed vector bench for mfp_ahb_master_arbiter
module tb_mfp_ahb_master_arbiter;

    localparam logic [1:0] ID = 2'b00;
    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] SQ = 2'b11;
    localparam logic [31:0] A0 = 32'h1FC0_0000;
    localparam logic [31:0] LA = 32'h0000_0010;

    logic        HCLK, HRESET;
    logic [31:0] m0_HADDR, m0_HWDATA, m0_HRDATA;
    logic [2:0]  m0_HBURST, m0_HSIZE;
    logic        m0_HMASTLOCK, m0_HWRITE, m0_HREADY, m0_HRESP;
    logic [3:0]  m0_HPROT;
    logic [1:0]  m0_HTRANS;
    logic [31:0] m1_HADDR, m1_HWDATA, m1_HRDATA;
    logic [2:0]  m1_HBURST, m1_HSIZE;
    logic        m1_HMASTLOCK, m1_HWRITE, m1_HREADY, m1_HRESP;
    logic [3:0]  m1_HPROT;
    logic [1:0]  m1_HTRANS;
    logic        m1_busreq;
    logic [31:0] s_HADDR, s_HWDATA, s_HRDATA;
    logic [2:0]  s_HBURST, s_HSIZE;
    logic        s_HMASTLOCK, s_HWRITE, s_HREADY, s_HRESP;
    logic [3:0]  s_HPROT;
    logic [1:0]  s_HTRANS;
    logic        addr_owner;
    logic [1:0]  buf_valid;

    mfp_ahb_master_arbiter #(.ADDR_W(32), .HONOR_LOCK(1'b1)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .m0_HADDR(m0_HADDR), .m0_HBURST(m0_HBURST), .m0_HMASTLOCK(m0_HMASTLOCK),
        .m0_HPROT(m0_HPROT), .m0_HSIZE(m0_HSIZE), .m0_HTRANS(m0_HTRANS),
        .m0_HWDATA(m0_HWDATA), .m0_HWRITE(m0_HWRITE),
        .m0_HRDATA(m0_HRDATA), .m0_HREADY(m0_HREADY), .m0_HRESP(m0_HRESP),
        .m1_HADDR(m1_HADDR), .m1_HBURST(m1_HBURST), .m1_HMASTLOCK(m1_HMASTLOCK),
        .m1_HPROT(m1_HPROT), .m1_HSIZE(m1_HSIZE), .m1_HTRANS(m1_HTRANS),
        .m1_HWDATA(m1_HWDATA), .m1_HWRITE(m1_HWRITE),
        .m1_HRDATA(m1_HRDATA), .m1_HREADY(m1_HREADY), .m1_HRESP(m1_HRESP),
        .m1_busreq(m1_busreq),
        .s_HADDR(s_HADDR), .s_HBURST(s_HBURST), .s_HMASTLOCK(s_HMASTLOCK),
        .s_HPROT(s_HPROT), .s_HSIZE(s_HSIZE), .s_HTRANS(s_HTRANS),
        .s_HWDATA(s_HWDATA), .s_HWRITE(s_HWRITE),
        .s_HRDATA(s_HRDATA), .s_HREADY(s_HREADY), .s_HRESP(s_HRESP),
        .addr_owner(addr_owner), .buf_valid(buf_valid)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        rst;
        logic        br;
        logic [1:0]  t0;
        logic [31:0] a0;
        logic        l0;
        logic [1:0]  t1;
        logic [31:0] a1;
        logic        sr;
        logic        e_ao;
        logic [1:0]  e_bv;
        logic        e_r0;
        logic        e_r1;
        logic [1:0]  e_st;
        logic [31:0] e_sa;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic vec_t mk(logic rst, logic br, logic [1:0] t0, logic [31:0] a0, logic l0,
                                logic [1:0] t1, logic [31:0] a1, logic sr,
                                logic e_ao, logic [1:0] e_bv, logic e_r0, logic e_r1,
                                logic [1:0] e_st, logic [31:0] e_sa);
        vec_t v;
        v.rst = rst; v.br = br; v.t0 = t0; v.a0 = a0; v.l0 = l0;
        v.t1 = t1; v.a1 = a1; v.sr = sr;
        v.e_ao = e_ao; v.e_bv = e_bv; v.e_r0 = e_r0; v.e_r1 = e_r1;
        v.e_st = e_st; v.e_sa = e_sa;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, check the settled
    // outputs, and leave the rising edge to commit the cycle.
    task automatic apply(input vec_t v, input string tag);
        @(negedge HCLK);
        HRESET       = v.rst;
        m1_busreq    = v.br;
        m0_HTRANS    = v.t0;
        m0_HADDR     = v.a0;
        m0_HMASTLOCK = v.l0;
        m1_HTRANS    = v.t1;
        m1_HADDR     = v.a1;
        s_HREADY     = v.sr;
        #1;
        chk({tag, " addr_owner"}, {31'd0, addr_owner}, {31'd0, v.e_ao});
        chk({tag, " buf_valid"},  {30'd0, buf_valid},  {30'd0, v.e_bv});
        chk({tag, " m0_HREADY"},  {31'd0, m0_HREADY},  {31'd0, v.e_r0});
        chk({tag, " m1_HREADY"},  {31'd0, m1_HREADY},  {31'd0, v.e_r1});
        chk({tag, " s_HTRANS"},   {30'd0, s_HTRANS},   {30'd0, v.e_st});
        chk({tag, " s_HADDR"},    s_HADDR,             v.e_sa);
    endtask

    vec_t tbl[21];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Row: rst busreq | m0 trans/addr/lock | m1 trans/addr | s_HREADY ||
        //      exp addr_owner buf_valid m0_HREADY m1_HREADY s_HTRANS s_HADDR
        // CPU streaming reads cut off by the loader, then replayed.
        tbl[0]  = mk(0, 0, NS, A0 + 0,  0, ID, LA, 1,  0, 2'b00, 1, 0, NS, A0 + 0);
        tbl[1]  = mk(0, 0, NS, A0 + 4,  0, ID, LA, 1,  0, 2'b00, 1, 0, NS, A0 + 4);
        tbl[2]  = mk(0, 1, NS, A0 + 8,  0, NS, LA, 1,  0, 2'b00, 1, 0, ID, A0 + 8);
        tbl[3]  = mk(0, 1, NS, A0 + 12, 0, NS, LA, 1,  1, 2'b01, 0, 1, NS, LA);
        tbl[4]  = mk(0, 1, NS, A0 + 12, 0, ID, LA, 1,  1, 2'b01, 0, 1, ID, LA);
        tbl[5]  = mk(0, 0, NS, A0 + 12, 0, ID, LA, 1,  1, 2'b01, 0, 1, ID, LA);
        tbl[6]  = mk(0, 0, NS, A0 + 12, 0, ID, LA, 1,  0, 2'b01, 0, 0, NS, A0 + 8);
        tbl[7]  = mk(0, 0, NS, A0 + 12, 0, ID, LA, 1,  0, 2'b00, 1, 0, NS, A0 + 12);
        tbl[8]  = mk(0, 0, NS, A0 + 16, 0, ID, LA, 0,  0, 2'b00, 0, 0, NS, A0 + 16);
        tbl[9]  = mk(0, 0, NS, A0 + 16, 0, ID, LA, 1,  0, 2'b00, 1, 0, NS, A0 + 16);
        // INCR4 burst: busreq rises at beat 2, handover only after beat 4.
        tbl[10] = mk(0, 0, NS, 32'h100, 0, ID, 32'h20, 1,  0, 2'b00, 1, 0, NS, 32'h100);
        tbl[11] = mk(0, 1, SQ, 32'h104, 0, NS, 32'h20, 1,  0, 2'b00, 1, 0, SQ, 32'h104);
        tbl[12] = mk(0, 1, SQ, 32'h108, 0, NS, 32'h20, 1,  0, 2'b00, 1, 0, SQ, 32'h108);
        tbl[13] = mk(0, 1, SQ, 32'h10C, 0, NS, 32'h20, 1,  0, 2'b00, 1, 0, SQ, 32'h10C);
        tbl[14] = mk(0, 1, ID, 32'h10C, 0, NS, 32'h20, 1,  0, 2'b00, 1, 0, ID, 32'h10C);
        tbl[15] = mk(0, 1, ID, 32'h10C, 0, NS, 32'h20, 1,  1, 2'b00, 0, 1, NS, 32'h20);
        // Back to CPU, which then holds HMASTLOCK against a loader request.
        tbl[16] = mk(0, 0, NS, 32'h200, 1, ID, 32'h20, 1,  1, 2'b00, 0, 1, ID, 32'h20);
        tbl[17] = mk(0, 1, NS, 32'h200, 1, NS, 32'h30, 1,  0, 2'b00, 1, 0, NS, 32'h200);
        tbl[18] = mk(0, 1, NS, 32'h204, 1, NS, 32'h30, 1,  0, 2'b00, 1, 0, NS, 32'h204);
        tbl[19] = mk(0, 1, NS, 32'h208, 0, NS, 32'h30, 1,  0, 2'b00, 1, 0, ID, 32'h208);
        tbl[20] = mk(0, 1, NS, 32'h20C, 0, NS, 32'h30, 1,  1, 2'b01, 0, 1, NS, 32'h30);

        m0_HBURST = 3'd0; m0_HPROT = 4'd3; m0_HSIZE = 3'd2; m0_HWRITE = 1'b0;
        m1_HBURST = 3'd0; m1_HPROT = 4'd3; m1_HSIZE = 3'd2; m1_HWRITE = 1'b0;
        m0_HWDATA = 32'h0; m1_HWDATA = 32'h0;
        s_HRDATA = 32'h0; s_HRESP = 1'b0;
        m0_HMASTLOCK = 1'b0; m1_HMASTLOCK = 1'b0;

        // Reset state.
        HRESET = 1'b1; m1_busreq = 1'b0; m0_HTRANS = ID; m1_HTRANS = ID;
        m0_HADDR = 32'h0; m1_HADDR = 32'h0; s_HREADY = 1'b1;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        chk("reset addr_owner", {31'd0, addr_owner}, 32'd0);
        chk("reset buf_valid",  {30'd0, buf_valid},  32'd0);
        chk("reset m1_HREADY",  {31'd0, m1_HREADY},  32'd0);

        for (int i = 0; i < 21; i++) apply(tbl[i], $sformatf("v%0d", i));

        // Three slave wait states on a pending loader-to-CPU handover.
        for (int i = 0; i < 3; i++)
            apply(mk(0, 0, NS, 32'h20C, 0, ID, 32'h30, 0,  1, 2'b01, 0, 0, ID, 32'h30),
                  $sformatf("wait%0d", i));
        apply(mk(0, 0, NS, 32'h20C, 0, ID, 32'h30, 1,  1, 2'b01, 0, 1, ID, 32'h30), "wait_end");
        // Replay is on the bus, but reset lands first: no replay afterwards.
        apply(mk(1, 0, NS, 32'h20C, 0, ID, 32'h30, 1,  0, 2'b01, 0, 0, NS, 32'h208), "rst_buf");
        apply(mk(0, 0, ID, 32'h20C, 0, ID, 32'h30, 1,  0, 2'b00, 1, 0, ID, 32'h20C), "post_rst");

        // Loader writes 0xDEADBEEF to 0x10; data and response routing.
        m1_HWRITE = 1'b1;
        apply(mk(0, 1, ID, 32'h20C, 0, NS, LA, 1,  0, 2'b00, 1, 0, ID, 32'h20C), "wr_ho");
        apply(mk(0, 1, ID, 32'h20C, 0, NS, LA, 1,  1, 2'b00, 0, 1, NS, LA), "wr_addr");
        chk("wr_addr s_HWRITE", {31'd0, s_HWRITE}, 32'd1);
        m1_HWDATA = 32'hDEAD_BEEF; m0_HWDATA = 32'h1111_1111;
        s_HRDATA = 32'hCAFE_F00D; s_HRESP = 1'b1; m1_HWRITE = 1'b0;
        apply(mk(0, 0, ID, 32'h20C, 0, ID, LA, 1,  1, 2'b00, 0, 1, ID, LA), "wr_data");
        chk("wr_data s_HWDATA", s_HWDATA, 32'hDEAD_BEEF);
        chk("m0_HRESP fanout", {31'd0, m0_HRESP}, 32'd1);
        chk("m1_HRESP fanout", {31'd0, m1_HRESP}, 32'd1);
        chk("m0_HRDATA fanout", m0_HRDATA, 32'hCAFE_F00D);
        s_HRESP = 1'b0;
        apply(mk(0, 0, ID, 32'h20C, 0, ID, LA, 1,  0, 2'b00, 1, 0, ID, 32'h20C), "back_cpu");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
